// File: rtl/sram_port_rr_arbiter.sv
// sram_port_rr_arbiter: N-channel round-robin (or fixed-select) arbiter in front
// of one single-port SRAM. It drives registered active-low CEN/WEN plus A/D, and
// returns read data tagged with the issuing channel after RD_LAT+1 cycles.
module sram_port_rr_arbiter #(
    parameter int N_CH    = 16,
    parameter int D_WIDTH = 16,
    parameter int A_WIDTH = 16,
    parameter int RD_LAT  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         req_i,
    input  logic [N_CH-1:0]         we_i,
    input  logic [N_CH*A_WIDTH-1:0] addr_i,
    input  logic [N_CH*D_WIDTH-1:0] data_i,
    input  logic                    fixed_mode_i,
    input  logic [$clog2(N_CH)-1:0] fixed_sel_i,
    output logic [N_CH-1:0]         grant_o,
    output logic                    CEN_out,
    output logic                    WEN_out,
    output logic [A_WIDTH-1:0]      A_out,
    output logic [D_WIDTH-1:0]      D_out,
    input  logic [D_WIDTH-1:0]      Q_in,
    output logic                    rd_valid_o,
    output logic [$clog2(N_CH)-1:0] rd_ch_o,
    output logic [D_WIDTH-1:0]      rd_data_o
);

    localparam int CH_W = $clog2(N_CH);

    logic [N_CH-1:0]    elig;
    logic               found;
    logic [CH_W-1:0]    win_ch;
    logic [CH_W:0]      scan_sum;
    logic [CH_W-1:0]    scan_ch;
    logic [CH_W-1:0]    ptr_q, ptr_d;
    logic [A_WIDTH-1:0] sel_addr;
    logic [D_WIDTH-1:0] sel_data;
    logic               sel_we;

    logic               cen_q, wen_q;
    logic [A_WIDTH-1:0] a_q;
    logic [D_WIDTH-1:0] d_q;

    // Read-tracking pipe: stage 0 holds the command currently on the port,
    // stage RD_LAT is the cycle Q_in carries that command's data.
    logic [RD_LAT:0]            pipe_vld_q;
    logic [RD_LAT:0][CH_W-1:0]  pipe_ch_q;

    logic               rd_valid_q;
    logic [CH_W-1:0]    rd_ch_q;
    logic [D_WIDTH-1:0] rd_data_q;

    // Eligible set: everything requested, or only the legacy-selected channel.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        elig = req_i;
        if (fixed_mode_i) begin
            elig = '0;
            // An out-of-range legacy select leaves nothing eligible.
            if ({1'b0, fixed_sel_i} < (CH_W+1)'(N_CH)) begin
                elig[fixed_sel_i] = req_i[fixed_sel_i];
            end
        end
    end

    // Round-robin search: first eligible channel at or above ptr_q, wrapping.
    always_comb begin
        found    = 1'b0;
        win_ch   = '0;
        scan_sum = '0;
        scan_ch  = '0;
        for (int i = 0; i < N_CH; i++) begin
            scan_sum = {1'b0, ptr_q} + (CH_W+1)'(i);
            if (scan_sum >= (CH_W+1)'(N_CH)) begin
                scan_sum = scan_sum - (CH_W+1)'(N_CH);
            end
            scan_ch = scan_sum[CH_W-1:0];
            if (!found && elig[scan_ch]) begin
                found  = 1'b1;
                win_ch = scan_ch;
            end
        end
    end

    // Winner's command fields, one-hot grant and the pointer that follows it.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_we   = 1'b0;
        grant_o  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (CH_W'(i) == win_ch) begin
                sel_addr = addr_i[i*A_WIDTH +: A_WIDTH];
                sel_data = data_i[i*D_WIDTH +: D_WIDTH];
                sel_we   = we_i[i];
            end
        end
        if (found) begin
            grant_o[win_ch] = 1'b1;
        end
        ptr_d = (win_ch == CH_W'(N_CH-1)) ? '0 : win_ch + CH_W'(1);
    end

    // SRAM command registers and arbitration pointer; A/D hold while idle.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            cen_q <= 1'b1;
            wen_q <= 1'b1;
            a_q   <= '0;
            d_q   <= '0;
            ptr_q <= '0;
        end else begin
            cen_q <= ~found;
            wen_q <= found ? ~sel_we : 1'b1;
            if (found) begin
                a_q   <= sel_addr;
                d_q   <= sel_data;
                ptr_q <= ptr_d;
            end
        end
    end

    // Shift (valid, channel) of each issued read alongside the SRAM latency.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: this small pipe is reset on purpose: in-flight reads must be dropped on reset.
        if (rst) begin
            pipe_vld_q <= '0;
            pipe_ch_q  <= '0;
        end else begin
            pipe_vld_q <= {pipe_vld_q[RD_LAT-1:0], found & ~sel_we};
            pipe_ch_q  <= {pipe_ch_q[RD_LAT-1:0], win_ch};
        end
    end

    // Capture Q_in as the tracked read leaves the pipe; tag and data hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_ch_q    <= '0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= pipe_vld_q[RD_LAT];
            if (pipe_vld_q[RD_LAT]) begin
                rd_ch_q   <= pipe_ch_q[RD_LAT];
                rd_data_q <= Q_in;
            end
        end
    end

    assign CEN_out    = cen_q;
    assign WEN_out    = wen_q;
    assign A_out      = a_q;
    assign D_out      = d_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_ch_o    = rd_ch_q;
    assign rd_data_o  = rd_data_q;

endmodule

// File: tb/tb_sram_port_rr_arbiter.sv
// Bench for sram_port_rr_arbiter: two instances (16 ch / RD_LAT=1 and 12 ch /
// RD_LAT=3) share one stimulus. A cycle-indexed command history plus an SRAM
// array predict every output each cycle; directed literals pin key results.
module tb_sram_port_rr_arbiter;

    localparam int AW   = 8;
    localparam int DW   = 16;
    localparam int MAXC = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   req, we;
    logic          fmode;
    logic [3:0]    fsel;
    logic [AW-1:0] addr_v [16];
    logic [DW-1:0] data_v [16];
    logic [16*AW-1:0] addr_flat;
    logic [16*DW-1:0] data_flat;
    logic [DW-1:0] q_in [2];

    logic [15:0]   gnt0;
    logic [11:0]   gnt1;
    logic [15:0]   act_gnt [2];
    logic          cen_o [2], wen_o [2], rdv_o [2];
    logic [AW-1:0] a_o [2];
    logic [DW-1:0] d_o [2], rdd_o [2];
    logic [3:0]    rdch_o [2];

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < 16; k++) begin
            addr_flat[k*AW +: AW] = addr_v[k];
            data_flat[k*DW +: DW] = data_v[k];
        end
    end

    assign act_gnt[0] = gnt0;
    assign act_gnt[1] = {4'b0, gnt1};

    sram_port_rr_arbiter #(.N_CH(16), .D_WIDTH(DW), .A_WIDTH(AW), .RD_LAT(1)) u0 (
        .clk(clk), .rst(rst), .req_i(req), .we_i(we),
        .addr_i(addr_flat), .data_i(data_flat),
        .fixed_mode_i(fmode), .fixed_sel_i(fsel), .grant_o(gnt0),
        .CEN_out(cen_o[0]), .WEN_out(wen_o[0]), .A_out(a_o[0]), .D_out(d_o[0]),
        .Q_in(q_in[0]), .rd_valid_o(rdv_o[0]), .rd_ch_o(rdch_o[0]), .rd_data_o(rdd_o[0])
    );

    sram_port_rr_arbiter #(.N_CH(12), .D_WIDTH(DW), .A_WIDTH(AW), .RD_LAT(3)) u1 (
        .clk(clk), .rst(rst), .req_i(req[11:0]), .we_i(we[11:0]),
        .addr_i(addr_flat[12*AW-1:0]), .data_i(data_flat[12*DW-1:0]),
        .fixed_mode_i(fmode), .fixed_sel_i(fsel), .grant_o(gnt1),
        .CEN_out(cen_o[1]), .WEN_out(wen_o[1]), .A_out(a_o[1]), .D_out(d_o[1]),
        .Q_in(q_in[1]), .rd_valid_o(rdv_o[1]), .rd_ch_o(rdch_o[1]), .rd_data_o(rdd_o[1])
    );

    // Model state: command visible on the port in each cycle, SRAM contents,
    // the Q value presented each cycle, and the outputs that hold.
    int            ptr_m [2];
    logic [AW-1:0] a_m [2];
    logic [DW-1:0] d_m [2], rdd_m [2];
    logic          rdv_m [2];
    int            rdch_m [2];
    logic          cv  [2][MAXC];
    logic          cwe [2][MAXC];
    logic [AW-1:0] ca  [2][MAXC];
    logic [DW-1:0] cd  [2][MAXC];
    logic [DW-1:0] cq  [2][MAXC];
    int            cch [2][MAXC];
    logic [DW-1:0] mem [2][256];
    int            cyc;

    // Snapshots of DUT outputs in the cycle most recently ticked.
    logic [15:0]   s_gnt [2];
    logic          s_cen [2], s_wen [2], s_rdv [2];
    logic [AW-1:0] s_a [2];
    logic [DW-1:0] s_d [2], s_rdd [2];
    logic [3:0]    s_rdch [2];

    int n_vec = 0;
    int n_bad = 0;

    function automatic int nch(input int g);
        return (g == 0) ? 16 : 12;
    endfunction

    function automatic int rdl(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // One arbitration cycle: present Q, compare all outputs to the model, advance.
    task automatic tick();
        int c, k, win, n, l, src;
        logic [15:0] gexp;
        c = cyc;
        for (int g = 0; g < 2; g++) begin
            l = rdl(g);
            if (c >= l && cv[g][c-l] && !cwe[g][c-l]) q_in[g] = mem[g][ca[g][c-l]];
            else q_in[g] = 16'h5A5A ^ 16'(c);
            cq[g][c] = q_in[g];
        end
        #1;
        for (int g = 0; g < 2; g++) begin
            n = nch(g);
            l = rdl(g);
            if (cv[g][c]) begin
                a_m[g] = ca[g][c];
                d_m[g] = cd[g][c];
            end
            src = c - 1 - l;
            if (src >= 0 && cv[g][src] && !cwe[g][src]) begin
                rdv_m[g]  = 1'b1;
                rdch_m[g] = cch[g][src];
                rdd_m[g]  = cq[g][c-1];
            end else begin
                rdv_m[g] = 1'b0;
            end
            win = -1;
            for (int i = 0; i < n; i++) begin
                k = (ptr_m[g] + i) % n;
                if (win < 0 && req[k] && (!fmode || k == int'(fsel))) win = k;
            end
            gexp = (win < 0) ? 16'h0 : (16'h1 << win);

            s_gnt[g] = act_gnt[g]; s_cen[g] = cen_o[g]; s_wen[g] = wen_o[g];
            s_a[g] = a_o[g]; s_d[g] = d_o[g]; s_rdv[g] = rdv_o[g];
            s_rdch[g] = rdch_o[g]; s_rdd[g] = rdd_o[g];

            check($sformatf("u%0d.grant", g), s_gnt[g], gexp);
            check($sformatf("u%0d.cen", g), s_cen[g], !cv[g][c]);
            check($sformatf("u%0d.wen", g), s_wen[g], cv[g][c] ? !cwe[g][c] : 1'b1);
            check($sformatf("u%0d.a", g), s_a[g], a_m[g]);
            check($sformatf("u%0d.d", g), s_d[g], d_m[g]);
            check($sformatf("u%0d.rd_valid", g), s_rdv[g], rdv_m[g]);
            check($sformatf("u%0d.rd_ch", g), s_rdch[g], rdch_m[g]);
            check($sformatf("u%0d.rd_data", g), s_rdd[g], rdd_m[g]);

            if (cv[g][c] && cwe[g][c]) mem[g][ca[g][c]] = cd[g][c];
            if (win >= 0) begin
                cv[g][c+1]  = 1'b1;
                cwe[g][c+1] = we[win];
                ca[g][c+1]  = addr_v[win];
                cd[g][c+1]  = data_v[win];
                cch[g][c+1] = win;
                ptr_m[g]    = (win + 1) % n;
            end else begin
                cv[g][c+1] = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Assert reset for one edge, check reset values, clear the model.
    task automatic do_reset();
        rst = 1'b1; req = '0; we = '0; fmode = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            check($sformatf("u%0d.rst_cen", g), cen_o[g], 1'b1);
            check($sformatf("u%0d.rst_wen", g), wen_o[g], 1'b1);
            check($sformatf("u%0d.rst_a", g), a_o[g], 0);
            check($sformatf("u%0d.rst_d", g), d_o[g], 0);
            check($sformatf("u%0d.rst_rdv", g), rdv_o[g], 0);
            check($sformatf("u%0d.rst_rdch", g), rdch_o[g], 0);
            check($sformatf("u%0d.rst_rdd", g), rdd_o[g], 0);
            ptr_m[g] = 0; a_m[g] = '0; d_m[g] = '0;
            rdv_m[g] = 1'b0; rdch_m[g] = 0; rdd_m[g] = '0;
            for (int c = 0; c < MAXC; c++) cv[g][c] = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc++;
    endtask

    initial begin
        cyc = 0;
        req = '0; we = '0; fmode = 1'b0; fsel = '0;
        q_in[0] = '0; q_in[1] = '0;
        for (int k = 0; k < 16; k++) begin
            addr_v[k] = 8'h40 + 8'(k);
            data_v[k] = 16'h1000 + 16'(k);
        end
        for (int g = 0; g < 2; g++) begin
            for (int a = 0; a < 256; a++) mem[g][a] = 16'hC000 ^ 16'(a * 3);
            mem[g][8'h10] = 16'hBEEF;
        end
        @(negedge clk);
        do_reset();

        // Round-robin fairness: all channels requesting for 32 cycles.
        req = 16'hFFFF; we = 16'hA5C3;
        for (int i = 0; i < 32; i++) begin
            tick();
            check("rr.grant", s_gnt[0], 32'h1 << (i % 16));
            if (i > 0) check("rr.cen", s_cen[0], 1'b0);
        end
        req = '0; we = '0;
        tick();
        check("rr.cen_last", s_cen[0], 1'b0);

        // Write command from ch5.
        addr_v[5] = 8'h2A; data_v[5] = 16'h1234;
        req = 16'h0020; we = 16'h0020;
        tick();
        check("wr.grant", s_gnt[0], 32'h20);
        req = '0; we = '0;
        tick();
        check("wr.cen", s_cen[0], 1'b0);
        check("wr.wen", s_wen[0], 1'b0);
        check("wr.a", s_a[0], 32'h2A);
        check("wr.d", s_d[0], 32'h1234);
        tick();
        check("wr.cen_idle", s_cen[0], 1'b1);
        check("wr.a_hold", s_a[0], 32'h2A);

        // Read return from ch7, address 0x10.
        addr_v[7] = 8'h10;
        req = 16'h0080;
        tick();
        check("rd.grant", s_gnt[0], 32'h80);
        req = '0;
        tick();
        tick();
        check("rd.u0_early", s_rdv[0], 1'b0);
        tick();
        check("rd.u0_valid", s_rdv[0], 1'b1);
        check("rd.u0_ch", s_rdch[0], 7);
        check("rd.u0_data", s_rdd[0], 32'hBEEF);
        tick();
        check("rd.u1_early", s_rdv[1], 1'b0);
        tick();
        check("rd.u1_valid", s_rdv[1], 1'b1);
        check("rd.u1_ch", s_rdch[1], 7);
        check("rd.u1_data", s_rdd[1], 32'hBEEF);

        // Wrap and skip: move pointer to 14, then requests on ch0 and ch3.
        req = 16'h2000;
        tick();
        check("wrap.g13", s_gnt[0], 32'h2000);
        req = 16'h0009;
        tick();
        check("wrap.g0", s_gnt[0], 32'h1);
        tick();
        check("wrap.g3", s_gnt[0], 32'h8);
        tick();
        check("wrap.g0b", s_gnt[0], 32'h1);
        req = '0;
        tick();

        // Fixed mode: only ch9, then a select beyond the 12-channel instance.
        fmode = 1'b1; fsel = 4'd9; req = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("fix.u0_g9", s_gnt[0], 32'h200);
            check("fix.u1_g9", s_gnt[1], 32'h200);
        end
        fsel = 4'd14;
        tick();
        check("fix.u0_g14", s_gnt[0], 32'h4000);
        check("fix.u1_none", s_gnt[1], 0);
        tick();
        check("fix.u1_idle", s_cen[1], 1'b1);
        fmode = 1'b0;
        tick();
        check("fix.resume", s_gnt[0], 32'h8000);
        req = '0;
        for (int i = 0; i < 5; i++) tick();

        // Reset one cycle after a read issue: no return, pointer back to 0.
        req = 16'h0080; we = '0;
        tick();
        check("rst.grant7", s_gnt[0], 32'h80);
        req = '0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rst.u0_no_rd", s_rdv[0], 1'b0);
            check("rst.u1_no_rd", s_rdv[1], 1'b0);
        end
        req = 16'hFFFF;
        tick();
        check("rst.u0_ptr0", s_gnt[0], 32'h1);
        check("rst.u1_ptr0", s_gnt[1], 32'h1);
        req = '0;
        for (int i = 0; i < 6; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
